// File: rtl/sw_event_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sw_event_ctrl_if
// Brief    : Avalon-MM PIO master bus plus event valid/ready port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface sw_event_ctrl_if #(
    parameter int DATA_W     = 18,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              irq;
    logic [1:0]        m_address;
    logic              m_chipselect;
    logic              m_write_n;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              ev_valid;
    logic              ev_ready;
    logic [DATA_W-1:0] ev_capture;
    logic [DATA_W-1:0] ev_level;
    logic [CNT_W-1:0]  ev_count;
    logic              busy;

    modport master (
        input  irq,
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_readdata,
        output ev_valid,
        input  ev_ready,
        output ev_capture,
        output ev_level,
        output ev_count,
        output busy
    );

    modport slave (
        output irq,
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_readdata,
        input  ev_valid,
        output ev_ready,
        input  ev_capture,
        input  ev_level,
        input  ev_count,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/sw_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sw_event_ctrl
// Brief    : Switch PIO service engine; queues edge/level events in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sw_event_ctrl #(
    parameter int                DATA_W     = 18,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] IRQ_MASK   = {DATA_W{1'b1}}
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sw_event_ctrl_if.master   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] c_st_boot     = 4'd0;
    localparam logic [3:0] c_st_init     = 4'd1;
    localparam logic [3:0] c_st_idle     = 4'd2;
    localparam logic [3:0] c_st_rd_cap   = 4'd3;
    localparam logic [3:0] c_st_cap_wait = 4'd4;
    localparam logic [3:0] c_st_clr      = 4'd5;
    localparam logic [3:0] c_st_rd_dat   = 4'd6;
    localparam logic [3:0] c_st_dat_wait = 4'd7;
    localparam logic [3:0] c_st_push     = 4'd8;

    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(FIFO_DEPTH);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [DATA_W-1:0] r_cap;
    logic [DATA_W-1:0] r_lvl;
    logic [DATA_W-1:0] r_mem_cap [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_lvl [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    logic              w_cs;
    logic              w_write_n;
    logic [1:0]        w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_full  = (r_count == c_full_cnt);
    assign w_valid = (r_count != '0);
    // Spurious interrupts (nothing captured) are dropped rather than queued.
    assign w_push  = (r_state == c_st_push) && (r_cap != '0);
    assign w_pop   = w_valid && bus.ev_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_boot:     w_state_nxt = c_st_init;
            c_st_init:     w_state_nxt = c_st_idle;
            c_st_idle:     if (bus.irq && !w_full) w_state_nxt = c_st_rd_cap;
            c_st_rd_cap:   w_state_nxt = c_st_cap_wait;
            c_st_cap_wait: w_state_nxt = c_st_clr;
            c_st_clr:      w_state_nxt = c_st_rd_dat;
            c_st_rd_dat:   w_state_nxt = c_st_dat_wait;
            c_st_dat_wait: w_state_nxt = c_st_push;
            c_st_push:     w_state_nxt = c_st_idle;
            default:       w_state_nxt = c_st_boot;
        endcase
    end

    // Bus outputs depend only on the state register, so a reset edge kills any access at once.
    always_comb begin
        w_cs      = 1'b0;
        w_write_n = 1'b1;
        w_addr    = 2'd0;
        w_wdata   = '0;
        case (r_state)
            c_st_init: begin
                w_cs      = 1'b1;
                w_write_n = 1'b0;
                w_addr    = 2'd2;
                w_wdata   = IRQ_MASK;
            end
            c_st_rd_cap, c_st_cap_wait: w_addr = 2'd3;
            c_st_clr: begin
                w_cs      = 1'b1;
                w_write_n = 1'b0;
                w_addr    = 2'd3;
                w_wdata   = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_boot;
            r_cap    <= '0;
            r_lvl    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_cap_wait) r_cap <= bus.m_readdata;
            if (r_state == c_st_dat_wait) r_lvl <= bus.m_readdata;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cap[r_wr_ptr] <= r_cap;
            r_mem_lvl[r_wr_ptr] <= r_lvl;
        end
    end

    assign bus.m_chipselect = w_cs;
    assign bus.m_write_n    = w_write_n;
    assign bus.m_address    = w_addr;
    assign bus.m_writedata  = w_wdata;
    assign bus.ev_valid     = w_valid;
    assign bus.ev_capture   = w_valid ? r_mem_cap[r_rd_ptr] : '0;
    assign bus.ev_level     = w_valid ? r_mem_lvl[r_rd_ptr] : '0;
    assign bus.ev_count     = r_count;
    assign bus.busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: doc/sw_event_ctrl.md
# sw_event_ctrl

Avalon-MM master controller that services the 18-bit switch PIO (`sw`) on behalf of the vending-machine control logic. It programs the PIO interrupt mask after reset, then on each PIO `irq` reads and clears the edge-capture register and samples the live switch levels. Each result is queued as an event in a small first-word-fall-through FIFO. The downstream selection/coin FSM consumes events through a valid/ready port instead of touching the PIO itself.

## Interface
- `DATA_W`, 18: PIO data width.
- `FIFO_DEPTH`, 4: event FIFO depth; power of two, at least 2.
- `IRQ_MASK`, 18'h3FFFF: value written to PIO register 2 at init.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `irq`  in  1  PIO interrupt.
- `m_address`  out  2  PIO register select.
- `m_chipselect`  out  1  PIO chip select.
- `m_write_n`  out  1  PIO write strobe, active low.
- `m_writedata`  out  DATA_W  PIO write data.
- `m_readdata`  in  DATA_W  PIO read data.
- `ev_valid`  out  1  FIFO head valid.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_capture`  out  DATA_W  head event: edge bits captured.
- `ev_level`  out  DATA_W  head event: switch levels.
- `ev_count`  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `busy`  out  1  service sequence in progress; high in any state except IDLE.

## Operation
- The PIO `readdata` is registered from `m_address`. Data for an address driven in cycle N is valid in cycle N+1.
- Avalon outputs are decoded from the state register.
  - Outside the listed cases, outputs are `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
- FSM states:
  - BOOT (reset state): no access. Next state INIT.
  - INIT: `m_chipselect`=1, `m_write_n`=0, `m_address`=2, `m_writedata`=IRQ_MASK. Next state IDLE.
  - IDLE: if `irq`=1 and `ev_count`<FIFO_DEPTH, next state RD_CAP; otherwise stay in IDLE.
  - RD_CAP: `m_address`=3. Next state CAP_WAIT.
  - CAP_WAIT: `m_address`=3. Latch `m_readdata` into `cap_r`. Next state CLR.
  - CLR: `m_chipselect`=1, `m_write_n`=0, `m_address`=3, `m_writedata`=all ones. Next state RD_DAT.
  - RD_DAT: `m_address`=0. Next state DAT_WAIT.
  - DAT_WAIT: `m_address`=0. Latch `m_readdata` into `lvl_r`. Next state PUSH.
  - PUSH: if `cap_r`≠0, write {`cap_r`,`lvl_r`} into the FIFO; if `cap_r`=0 (spurious), drop it. Next state IDLE.
- FIFO pop occurs when `ev_valid` && `ev_ready`. Push and pop in the same cycle leave `ev_count` unchanged.
- The FIFO can never overflow: IDLE gates entry on not-full, only one event is in flight at a time, and pops only free space.
- FIFO full: the controller stays in IDLE. `irq` stays high and further edges accumulate (OR-coalesce) in the PIO until space frees.
- Edges arriving between RD_CAP and CLR are cleared and lost. This is accepted; switch debounce time far exceeds the 2-cycle window.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - state BOOT; `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
  - FIFO empty: `ev_valid`=0, `ev_count`=0, `ev_capture`=0, `ev_level`=0.
  - `busy`=1.
- After reset release: BOOT for 1 cycle, INIT write in cycle 2, IDLE from cycle 3.
- Service latency: `irq` high in IDLE at cycle 0 gives RD_CAP in cycle 1, CLR write in cycle 3, PUSH in cycle 6, and `ev_valid` high in cycle 7.
- The PIO `irq` drops in cycle 4 unless a new edge arrives.
- Back-to-back service: an IDLE cycle always separates sequences, so the minimum service period is 7 cycles.
- `reset` mid-sequence: at the next edge, state returns to BOOT and the FIFO is emptied. Any in-flight event is discarded. No partial write is issued after the reset edge.

## Test plan
- Reset for 3 cycles, then release: exactly one write to address 2 with data 18'h3FFFF two cycles after release, and no other accesses.
- PIO bit 5 rising edge: read of address 3, then write to address 3 and read of address 0. `ev_valid` rises 7 cycles after `irq`, with `ev_capture`=18'h00020 and `ev_level` showing bit 5=1. `ev_count` goes 0→1, then →0 after one `ev_ready` cycle.
- `irq` forced high with the capture register reading 0: the clear write is still issued, no push occurs, and `ev_count` stays 0.
- `ev_ready`=0 with edges on bits 0,1,2,3 then bit 4 (FIFO_DEPTH=4): `ev_count`=4 and the controller holds in IDLE with `irq` high. After one pop, bit 4 is serviced and `ev_count` returns to 4.
- Pop on the same cycle as a PUSH with `ev_count`=2: `ev_count` stays 2 and event order is preserved.
- Assert `reset` during CLR: the next cycle shows BOOT outputs, `ev_count`=0, and after release exactly one INIT write occurs.
